// File: rtl/prbs9_qpsk_checker.sv
// Receive-side BER checker: slices QPSK I/Q by sign, self-synchronises a local
// PRBS9 (x^9+x^5+1), then counts bit errors and compared bits while locked.
module prbs9_qpsk_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_CNT   = 32,
    parameter int ERR_WIN    = 64,
    parameter int ERR_THR    = 8,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] rx_i,
    input  logic [DATA_WIDTH-1:0] rx_q,
    input  logic                  cnt_clr,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [CNT_W-1:0]      bit_cnt,
    output logic [CNT_W-1:0]      bit_err_cnt
);

    localparam int FILL_SYMS = 5;
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(ERR_WIN);
    localparam int EW = $clog2(ERR_THR + 2);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t        state;
    logic [8:0]    r;
    logic [2:0]    fill_cnt;
    logic [MW-1:0] match_cnt;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] err_win;

    logic          b_i, b_q, p_i, p_q, e_i, e_q;
    logic [1:0]    errs;
    logic [CNT_W:0]   bit_sum, err_sum;
    logic [CNT_W-1:0] bit_next, err_next;
    logic [EW:0]   win_err_sum;

    always_comb begin
        b_i  = rx_i[DATA_WIDTH-1];
        b_q  = rx_q[DATA_WIDTH-1];
        p_i  = r[8] ^ r[4];
        p_q  = r[7] ^ r[3];
        e_i  = b_i ^ p_i;
        e_q  = b_q ^ p_q;
        errs = {1'b0, e_i} + {1'b0, e_q};
        bit_sum  = {1'b0, bit_cnt} + (CNT_W+1)'(2);
        err_sum  = {1'b0, bit_err_cnt} + (CNT_W+1)'(errs);
        // Carry out means the add wrapped: pin at all-ones instead.
        bit_next = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        err_next = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        win_err_sum = (EW+1)'(err_win) + (EW+1)'(errs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            r           <= '0;
            fill_cnt    <= '0;
            match_cnt   <= '0;
            win_cnt     <= '0;
            err_win     <= '0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            bit_cnt     <= '0;
            bit_err_cnt <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (en) begin
                if (state == HUNT) begin
                    r <= {r[6:0], b_i, b_q};
                    if (fill_cnt != 3'(FILL_SYMS)) begin
                        fill_cnt <= fill_cnt + 3'd1;
                    // r==0 never matches, so a constant +A input cannot lock.
                    end else if (!e_i && !e_q && r != 9'd0) begin
                        if (match_cnt == MW'(LOCK_CNT - 1)) begin
                            state     <= LOCK;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            err_win   <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end else begin
                        match_cnt <= '0;
                    end
                end else begin
                    // Free-run on predictions so a received error never enters r.
                    r         <= {r[6:0], p_i, p_q};
                    err_pulse <= |errs;
                    bit_cnt     <= bit_next;
                    bit_err_cnt <= err_next;
                    if (win_err_sum >= (EW+1)'(ERR_THR)) begin
                        state     <= HUNT;
                        locked    <= 1'b0;
                        fill_cnt  <= '0;
                        match_cnt <= '0;
                    end
                    if (win_cnt == WW'(ERR_WIN - 1)) begin
                        win_cnt <= '0;
                        err_win <= '0;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                        err_win <= win_err_sum[EW-1:0];
                    end
                end
            end
            if (cnt_clr) begin
                bit_cnt     <= '0;
                bit_err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs9_qpsk_checker.sv
// Directed bench for prbs9_qpsk_checker: a local PRBS9 source feeds clean or
// deliberately corrupted QPSK symbols; expected counts are worked out by hand.
module tb_prbs9_qpsk_checker;

    localparam int DW = 16;
    localparam int CW = 32;
    localparam logic [DW-1:0] AMP = 16'd1000;

    logic          clk = 1'b0;
    logic          rst, en, cnt_clr;
    logic [DW-1:0] rx_i, rx_q;
    logic          locked, err_pulse;
    logic [CW-1:0] bit_cnt, bit_err_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int ep_seen;
    int lk_seen;
    logic [8:0] h = 9'h1FF;   // source history, h[0] newest

    always #5 clk = ~clk;

    prbs9_qpsk_checker #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .rx_i(rx_i), .rx_q(rx_q),
        .cnt_clr(cnt_clr), .locked(locked), .err_pulse(err_pulse),
        .bit_cnt(bit_cnt), .bit_err_cnt(bit_err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic [DW-1:0] i, input logic [DW-1:0] q,
                        input logic clr);
        en = e; rx_i = i; rx_q = q; cnt_clr = clr;
        @(posedge clk); #1;
        if (err_pulse === 1'b1) ep_seen++;
        if (locked === 1'b1) lk_seen++;
    endtask

    function automatic logic [DW-1:0] map(input logic b);
        return b ? -AMP : AMP;
    endfunction

    // Next source symbol, I bit first; flip_* inverts the transmitted sign.
    task automatic sym(input logic flip_i, input logic flip_q, input logic clr);
        logic bi, bq;
        bi = h[8] ^ h[4]; h = {h[7:0], bi};
        bq = h[8] ^ h[4]; h = {h[7:0], bq};
        step(1'b1, map(bi ^ flip_i), map(bq ^ flip_q), clr);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cnt_clr = 1'b0; rx_i = '0; rx_q = '0;
        ep_seen = 0; lk_seen = 0;

        for (int k = 0; k < 5; k++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), 1'b0);
            chk("reset_outputs", {locked, err_pulse, bit_cnt, bit_err_cnt}, 64'd0);
        end
        rst = 1'b0;

        // Clean stream: 5 fill + 32 match before lock.
        ep_seen = 0;
        for (int k = 1; k <= 1000; k++) begin
            sym(1'b0, 1'b0, 1'b0);
            if (k == 36) chk("lock_not_yet", locked, 0);
            if (k == 37) chk("lock_at_37", locked, 1);
        end
        chk("clean_no_pulse", ep_seen, 0);
        chk("clean_err_cnt", bit_err_cnt, 0);
        chk("clean_bit_cnt", bit_cnt, 1926);

        ep_seen = 0; lk_seen = 0;
        for (int k = 0; k < 10; k++)
            step(1'b0, DW'($urandom), DW'($urandom), 1'b0);
        chk("pause_locked", lk_seen, 10);
        chk("pause_bit_cnt", bit_cnt, 1926);
        chk("pause_no_pulse", ep_seen, 0);
        for (int k = 0; k < 50; k++) sym(1'b0, 1'b0, 1'b0);
        chk("resume_bit_cnt", bit_cnt, 2026);
        chk("resume_err_cnt", bit_err_cnt, 0);

        // Single I error on locked symbol 1014.
        sym(1'b1, 1'b0, 1'b0);
        chk("single_pulse", err_pulse, 1);
        chk("single_err_cnt", bit_err_cnt, 1);
        chk("single_bit_cnt", bit_cnt, 2028);
        // 74 clean symbols bring the locked count to 1088, a window boundary.
        ep_seen = 0;
        for (int k = 0; k < 74; k++) sym(1'b0, 1'b0, 1'b0);
        chk("single_no_more", ep_seen, 0);
        chk("single_err_hold", bit_err_cnt, 1);
        chk("single_locked", locked, 1);
        chk("single_bit_cnt2", bit_cnt, 2176);

        step(1'b0, '0, '0, 1'b1);
        chk("clr_counts", {bit_cnt, bit_err_cnt}, 64'd0);
        chk("clr_keeps_lock", locked, 1);

        // Burst of 8 Q errors inside one fresh window.
        for (int k = 1; k <= 8; k++) begin
            sym(1'b0, 1'b1, 1'b0);
            chk("burst_pulse", err_pulse, 1);
            chk("burst_locked", locked, (k < 8) ? 1 : 0);
        end
        chk("burst_err_cnt", bit_err_cnt, 8);
        chk("burst_bit_cnt", bit_cnt, 16);
        for (int k = 1; k <= 37; k++) begin
            sym(1'b0, 1'b0, 1'b0);
            if (k == 36) chk("relock_not_yet", locked, 0);
            if (k == 37) chk("relock_at_37", locked, 1);
        end
        chk("relock_bit_cnt", bit_cnt, 16);

        // Mid-run reset then constant +A input must never lock.
        rst = 1'b1;
        step(1'b1, map(1'b1), map(1'b1), 1'b0);
        chk("midrst_outputs", {locked, err_pulse, bit_cnt, bit_err_cnt}, 64'd0);
        rst = 1'b0;
        lk_seen = 0;
        for (int k = 0; k < 200; k++) step(1'b1, AMP, AMP, 1'b0);
        chk("const_never_lock", lk_seen, 0);
        chk("const_bit_cnt", bit_cnt, 0);

        for (int k = 0; k < 37; k++) sym(1'b0, 1'b0, 1'b0);
        chk("const_relock", locked, 1);
        for (int k = 0; k < 3; k++) sym(1'b0, 1'b0, 1'b0);
        chk("pre_clr_bit_cnt", bit_cnt, 6);
        sym(1'b1, 1'b0, 1'b1);
        chk("clr_wins_pulse", err_pulse, 1);
        chk("clr_wins_bit_cnt", bit_cnt, 0);
        chk("clr_wins_err_cnt", bit_err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs9_qpsk_checker.md
Name: prbs9_qpsk_checker

Overview:
- Receive-side BER checker directly downstream of tx_top.
- Consumes the 16-bit signed QPSK I/Q symbol stream produced from the PRBS9 source and slices each rail by sign to recover two bits per symbol.
- Self-synchronises a local PRBS9 (x^9+x^5+1), declares lock, then counts bit errors and bits compared.
- Used in loopback benches and on hardware to qualify the TX path and, later, the channel/equaliser chain.

Parameters:
- DATA_WIDTH, 16: width of rx_i/rx_q, two's complement.
- LOCK_CNT, 32: consecutive error-free symbols required to enter LOCK.
- ERR_WIN, 64: length in symbols of the error-monitoring window while locked.
- ERR_THR, 8: bit errors within one window that force loss of lock.
- CNT_W, 32: width of bit_cnt and bit_err_cnt.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  symbol valid; one symbol per cycle with en=1, same strobe as tx_top en.
- rx_i  in  DATA_WIDTH  received I symbol, signed.
- rx_q  in  DATA_WIDTH  received Q symbol, signed.
- cnt_clr  in  1  synchronous clear of bit_cnt and bit_err_cnt.
- locked  out  1  high while in LOCK.
- err_pulse  out  1  one-cycle pulse: a locked symbol had at least one bit error.
- bit_cnt  out  CNT_W  bits compared while locked, saturating.
- bit_err_cnt  out  CNT_W  bit errors while locked, saturating.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. rst=1 at a clk edge sets state=HUNT, the 9-bit register r=0, all internal counters=0, and locked=0, err_pulse=0, bit_cnt=0, bit_err_cnt=0. This applies mid-operation too.
- Slicing: bit = sign bit (MSB). Negative → 1; zero or positive → 0. This matches the TX mapping 0→+A, 1→−A.
- Bit order: I bit precedes Q bit in the PRBS sequence. r[0] holds the newest bit.
- Prediction: pI = r[8]^r[4], pQ = r[7]^r[3]. Both are valid in either state.
- Register update, HUNT: r <= {r[6:0], bI, bQ} (received bits).
- Register update, LOCK: r <= {r[6:0], pI, pQ} (free-run, so a single error does not propagate).
- en=0: no state, register, counter or output change; err_pulse=0.
- HUNT, fill phase: the first 5 valid symbols after HUNT entry only fill r; no comparison is made.
- HUNT, matching: a symbol with bI==pI, bQ==pQ and r!=0 increments match_cnt. Any mismatch, or r==0, clears match_cnt. The r==0 rule prevents false lock on a constant +A input.
- HUNT → LOCK: when match_cnt reaches LOCK_CNT, the state goes to LOCK and locked=1 on that same edge. Window and error-in-window counters reset to 0.
- LOCK, per valid symbol:
  - errs = (bI!=pI) + (bQ!=pQ), range 0..2.
  - err_pulse=1 for one cycle if errs>0.
  - bit_cnt += 2; bit_err_cnt += errs.
  - Both counters saturate at all-ones: if the add would overflow, hold at max.
  - win_cnt increments and err_win += errs.
  - When win_cnt completes ERR_WIN symbols, both win_cnt and err_win restart at 0.
- LOCK → HUNT: when err_win+errs ≥ ERR_THR, at the same edge: locked=0, fill and match counters reset. r is kept but is reloaded by the fill phase. That symbol is still counted.
- Latency: all outputs are registered, 1 cycle after the sampling edge of the symbol.
- cnt_clr: clears bit_cnt and bit_err_cnt at the edge. cnt_clr wins over a simultaneous increment; that symbol is not counted. cnt_clr does not affect lock state or window counters.

Test Plan:
- Reset: hold rst=1 for 5 cycles with random rx/en → locked=0, err_pulse=0, bit_cnt=0, bit_err_cnt=0 on every cycle.
- Clean stream from tx_top, en=1, 1000 symbols:
  - locked rises one cycle after the 37th valid symbol (5 fill + 32 match).
  - bit_err_cnt stays 0.
  - bit_cnt = 2*(1000−37) = 1926 at the end.
- Pause: drop en for 10 cycles mid-LOCK → counters and locked are frozen, err_pulse=0. Resume 50 symbols → bit_cnt increases by exactly 100, no errors.
- Single error: negate rx_i on one symbol while locked → one err_pulse, bit_err_cnt=1, bit_cnt unaffected by the error, locked stays 1, no further errors.
- Burst: negate rx_q for 8 consecutive locked symbols inside one window → bit_err_cnt=8, locked falls after the 8th. Restore clean data → relock after 37 more symbols.
- Degenerate input: constant rx_i=rx_q=+1000 for 200 symbols → locked never asserts, bit_cnt=0. Assert cnt_clr together with an erroring locked symbol → both counters read 0 the next cycle.
